// File: rtl/fetch_pkg.sv
// Shared constants for the fetch sequencer: state encodings, PC mux selects, widths.
package fetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SEL_W   = 4;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [SEL_W-1:0] SEL_TGT = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_SEQ = 4'b0010;

  // Counter reload value that makes WAIT last exactly lat cycles.
  function automatic logic [CNT_W-1:0] lat_reload(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable 4-bit down-counter that tracks remaining memory latency.
module lat_counter
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  // Load wins over decrement; saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC mux/enable, waits out memory latency, and
// presents each instruction to decode on a valid/ready handshake.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       MEM_LAT   = 1,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         mem_hi,
  input  logic [7:0]         mem_lo,
  input  logic               instr_ready,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_addr,
  input  logic               halt_req,
  output logic [SEL_W-1:0]   pc_sel,
  output logic               pc_en,
  output logic [ADDR_W-1:0]  tgt_addr,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [15:0]        fetch_count,
  output logic               misalign_err,
  output logic               halted
);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               valid_q;
  logic               halted_q;
  logic [INSTR_W-1:0] instr_q;
  logic [15:0]        count_q;
  logic               mis_q;

  logic               cnt_load;
  logic               cnt_zero;
  logic [CNT_W-1:0]   cnt_value;
  logic               take_redir;
  logic               handshake;
  logic               latch;

  lat_counter u_lat (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (lat_reload(MEM_LAT)),
    .dec        (state == ST_WAIT),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

  // Next state and PC control; a redirect overrides everything outside BOOT.
  always_comb begin
    state_nxt  = state;
    pc_en      = 1'b0;
    pc_sel     = SEL_SEQ;
    tgt_addr   = BOOT_ADDR;
    cnt_load   = 1'b0;
    take_redir = 1'b0;
    handshake  = 1'b0;
    latch      = 1'b0;
    case (state)
      ST_BOOT: begin
        pc_en     = 1'b1;
        pc_sel    = SEL_TGT;
        cnt_load  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (redir_valid) begin
          take_redir = 1'b1;
        end else if (cnt_zero) begin
          latch     = 1'b1;
          state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (redir_valid) begin
          take_redir = 1'b1;
        end else if (instr_ready) begin
          handshake = 1'b1;
          if (halt_req) begin
            state_nxt = ST_HALT;
          end else begin
            pc_en     = 1'b1;
            pc_sel    = SEL_SEQ;
            cnt_load  = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_HALT: begin
        if (redir_valid) take_redir = 1'b1;
      end
      default: state_nxt = ST_BOOT;
    endcase
    if (take_redir) begin
      pc_en     = 1'b1;
      pc_sel    = SEL_TGT;
      tgt_addr  = {redir_addr[ADDR_W-1:1], 1'b0};
      cnt_load  = 1'b1;
      state_nxt = ST_WAIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_BOOT;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      instr_q  <= '0;
      count_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      valid_q  <= (state_nxt == ST_VALID);
      halted_q <= (state_nxt == ST_HALT);
      if (latch)                        instr_q <= {mem_hi, mem_lo};
      if (handshake)                    count_q <= count_q + 16'd1;
      if (take_redir && redir_addr[0])  mis_q   <= 1'b1;
    end
  end

  // A same-cycle redirect retracts the offer to decode.
  assign instr_valid  = valid_q & ~redir_valid;
  assign instr_out    = instr_q;
  assign fetch_count  = count_q;
  assign misalign_err = mis_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: two instances (MEM_LAT=1 and MEM_LAT=3) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  localparam int M_BOOT  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_VALID = 2;
  localparam int M_HALT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, ready, redir, halt;
  logic [1:0][15:0] raddr;
  logic [1:0][15:0] mdata;
  logic [1:0][3:0]  sel;
  logic [1:0]       pc_en, ivalid, mis, halted;
  logic [1:0][15:0] tgt, iout, cnt;
  logic [1:0][15:0] pc;
  logic [1:0][3:0]  age;

  fetch_ctrl #(.ADDR_W(16), .MEM_LAT(LAT0), .BOOT_ADDR(16'h0000)) dut0 (
    .clk(clk), .reset(rst[0]), .mem_hi(mdata[0][15:8]), .mem_lo(mdata[0][7:0]),
    .instr_ready(ready[0]), .redir_valid(redir[0]), .redir_addr(raddr[0]), .halt_req(halt[0]),
    .pc_sel(sel[0]), .pc_en(pc_en[0]), .tgt_addr(tgt[0]), .instr_valid(ivalid[0]),
    .instr_out(iout[0]), .fetch_count(cnt[0]), .misalign_err(mis[0]), .halted(halted[0]));

  fetch_ctrl #(.ADDR_W(16), .MEM_LAT(LAT1), .BOOT_ADDR(16'h0000)) dut1 (
    .clk(clk), .reset(rst[1]), .mem_hi(mdata[1][15:8]), .mem_lo(mdata[1][7:0]),
    .instr_ready(ready[1]), .redir_valid(redir[1]), .redir_addr(raddr[1]), .halt_req(halt[1]),
    .pc_sel(sel[1]), .pc_en(pc_en[1]), .tgt_addr(tgt[1]), .instr_valid(ivalid[1]),
    .instr_out(iout[1]), .fetch_count(cnt[1]), .misalign_err(mis[1]), .halted(halted[1]));

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0] ^ 8'h12, a[15:8] ^ 8'h34};
  endfunction

  // Datapath and memory: PC register plus a memory whose data is garbage until MEM_LAT cycles after a PC load.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pc_en[i]) begin
        pc[i]  <= (sel[i] == SEL_TGT) ? tgt[i] : pc[i] + 16'd2;
        age[i] <= 4'd0;
      end else if (age[i] != 4'hF) begin
        age[i] <= age[i] + 4'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++)
      mdata[i] = (int'(age[i]) >= lat_of(i) - 1) ? mem_word(pc[i]) : 16'hDEAD;
  end

  typedef struct {
    int          mode;
    int          wait_left;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] count;
    logic        mis;
  } mdl_t;

  mdl_t m [2];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = M_BOOT; r.wait_left = 0; r.addr = 16'h0000;
    r.instr = 16'h0000; r.count = 16'h0000; r.mis = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t s, input bit rv, input logic [15:0] ra,
                                 input bit rdy, input bit hr, input int lat);
    mdl_t n;
    n = s;
    if (s.mode == M_BOOT) begin
      n.mode = M_WAIT; n.wait_left = lat; n.addr = 16'h0000;
    end else if (rv) begin
      n.mode = M_WAIT; n.wait_left = lat; n.addr = {ra[15:1], 1'b0}; n.mis = s.mis | ra[0];
    end else if (s.mode == M_WAIT) begin
      n.wait_left = s.wait_left - 1;
      if (n.wait_left == 0) begin
        n.instr = mem_word(s.addr);
        n.mode  = M_VALID;
      end
    end else if (s.mode == M_VALID && rdy) begin
      n.count = s.count + 16'd1;
      if (hr) n.mode = M_HALT;
      else begin
        n.addr = s.addr + 16'd2; n.mode = M_WAIT; n.wait_left = lat;
      end
    end
    return n;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    bit          exp_en, exp_v;
    logic [3:0]  exp_sel;
    logic [15:0] exp_tgt;
    #2;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) m[i] = mdl_reset();
      exp_en = 1'b0; exp_v = 1'b0; exp_sel = SEL_SEQ; exp_tgt = 16'h0000;
      if (m[i].mode == M_BOOT) begin
        exp_en = 1'b1; exp_sel = SEL_TGT;
      end else if (redir[i]) begin
        exp_en = 1'b1; exp_sel = SEL_TGT; exp_tgt = {raddr[i][15:1], 1'b0};
      end else if (m[i].mode == M_VALID) begin
        exp_v = 1'b1;
        if (ready[i] && !halt[i]) exp_en = 1'b1;
      end
      chk($sformatf("pc_en[%0d]", i), 32'(pc_en[i]), 32'(exp_en));
      if (exp_en) chk($sformatf("pc_sel[%0d]", i), 32'(sel[i]), 32'(exp_sel));
      chk($sformatf("tgt_addr[%0d]", i), 32'(tgt[i]), 32'(exp_tgt));
      chk($sformatf("instr_valid[%0d]", i), 32'(ivalid[i]), 32'(exp_v));
      chk($sformatf("halted[%0d]", i), 32'(halted[i]), 32'(m[i].mode == M_HALT));
      chk($sformatf("instr_out[%0d]", i), 32'(iout[i]), 32'(m[i].instr));
      chk($sformatf("fetch_count[%0d]", i), 32'(cnt[i]), 32'(m[i].count));
      chk($sformatf("misalign[%0d]", i), 32'(mis[i]), 32'(m[i].mis));
      if (!rst[i]) m[i] = mstep(m[i], redir[i], raddr[i], ready[i], halt[i], lat_of(i));
    end
  end

  initial begin
    rst = 2'b11; ready = '0; redir = '0; halt = '0; raddr = '0;
    repeat (3) @(negedge clk);

    // Reset release and first fetch with MEM_LAT=1.
    ready[0] = 1'b1; rst[0] = 1'b0;
    #3 chk("t1_boot_en", 32'(pc_en[0]), 32'd1); chk("t1_boot_sel", 32'(sel[0]), 32'(SEL_TGT));
    @(negedge clk);
    #3 chk("t1_wait_valid", 32'(ivalid[0]), 32'd0);
    @(negedge clk);
    #3 chk("t1_valid", 32'(ivalid[0]), 32'd1); chk("t1_instr", 32'(iout[0]), 32'h1234);
    @(negedge clk); ready[0] = 1'b0;
    #3 chk("t1_count", 32'(cnt[0]), 32'd1);

    // Decode stalls for five cycles.
    repeat (5) begin
      @(negedge clk);
      #3 chk("t2_hold_valid", 32'(ivalid[0]), 32'd1); chk("t2_hold_instr", 32'(iout[0]), 32'h1034);
      chk("t2_hold_en", 32'(pc_en[0]), 32'd0); chk("t2_hold_count", 32'(cnt[0]), 32'd1);
    end
    @(negedge clk); ready[0] = 1'b1;
    #3 chk("t2_accept_en", 32'(pc_en[0]), 32'd1); chk("t2_accept_sel", 32'(sel[0]), 32'(SEL_SEQ));
    @(negedge clk);
    #3 chk("t2_count", 32'(cnt[0]), 32'd2);

    // Redirect while an instruction is offered.
    @(negedge clk); redir[0] = 1'b1; raddr[0] = 16'h0040;
    #3 chk("t3_valid_drop", 32'(ivalid[0]), 32'd0); chk("t3_tgt", 32'(tgt[0]), 32'h0040);
    chk("t3_sel", 32'(sel[0]), 32'(SEL_TGT)); chk("t3_en", 32'(pc_en[0]), 32'd1);
    @(negedge clk); redir[0] = 1'b0;
    #3 chk("t3_no_count", 32'(cnt[0]), 32'd2);
    @(negedge clk);
    #3 chk("t3_instr", 32'(iout[0]), 32'h5234);

    // Odd redirect during WAIT.
    @(negedge clk); redir[0] = 1'b1; raddr[0] = 16'h0041;
    #3 chk("t4_tgt_aligned", 32'(tgt[0]), 32'h0040); chk("t4_en", 32'(pc_en[0]), 32'd1);
    @(negedge clk); redir[0] = 1'b0;
    #3 chk("t4_misalign", 32'(mis[0]), 32'd1); chk("t4_restart", 32'(ivalid[0]), 32'd0);
    @(negedge clk);
    #3 chk("t4_instr", 32'(iout[0]), 32'h5234); chk("t4_count", 32'(cnt[0]), 32'd3);

    // Halt at a handshake, then resume by redirect.
    @(negedge clk);
    @(negedge clk); halt[0] = 1'b1;
    #3 chk("t5_hs_valid", 32'(ivalid[0]), 32'd1); chk("t5_hs_en", 32'(pc_en[0]), 32'd0);
    @(negedge clk); halt[0] = 1'b0;
    #3 chk("t5_halted", 32'(halted[0]), 32'd1);
    repeat (4) begin
      @(negedge clk);
      #3 chk("t5_halt_hold", 32'(halted[0]), 32'd1); chk("t5_halt_en", 32'(pc_en[0]), 32'd0);
      chk("t5_halt_count", 32'(cnt[0]), 32'd5);
    end
    @(negedge clk); redir[0] = 1'b1; raddr[0] = 16'h0100;
    #3 chk("t5_redir_en", 32'(pc_en[0]), 32'd1); chk("t5_redir_tgt", 32'(tgt[0]), 32'h0100);
    @(negedge clk); redir[0] = 1'b0;
    #3 chk("t5_unhalted", 32'(halted[0]), 32'd0);
    @(negedge clk);
    #3 chk("t5_instr", 32'(iout[0]), 32'h1235); chk("t5_mis_sticky", 32'(mis[0]), 32'd1);

    // MEM_LAT=3: exact WAIT length, count wrap, async reset mid-WAIT.
    @(negedge clk); rst[0] = 1'b1; ready[1] = 1'b0; rst[1] = 1'b0;
    #3 chk("t6_boot_en", 32'(pc_en[1]), 32'd1);
    @(negedge clk); force dut1.count_q = 16'hFFFE; m[1].count = 16'hFFFE;
    #3 chk("t6_wait1", 32'(ivalid[1]), 32'd0);
    @(negedge clk); release dut1.count_q;
    #3 chk("t6_wait2", 32'(ivalid[1]), 32'd0);
    @(negedge clk);
    #3 chk("t6_wait3", 32'(ivalid[1]), 32'd0); chk("t6_preset", 32'(cnt[1]), 32'hFFFE);
    @(negedge clk); ready[1] = 1'b1;
    #3 chk("t6_valid", 32'(ivalid[1]), 32'd1); chk("t6_instr", 32'(iout[1]), 32'h1234);
    @(negedge clk);
    #3 chk("t6_count_ffff", 32'(cnt[1]), 32'hFFFF);
    repeat (2) @(negedge clk);
    @(negedge clk);
    #3 chk("t6_valid2", 32'(ivalid[1]), 32'd1); chk("t6_instr2", 32'(iout[1]), 32'h1034);
    @(negedge clk); redir[1] = 1'b1; raddr[1] = 16'h0081;
    #3 chk("t6_wrap", 32'(cnt[1]), 32'd0); chk("t6_tgt", 32'(tgt[1]), 32'h0080);
    @(negedge clk); redir[1] = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    #3 chk("t6_instr3", 32'(iout[1]), 32'h9234); chk("t6_mis", 32'(mis[1]), 32'd1);
    @(negedge clk);
    @(negedge clk); rst[1] = 1'b1;
    #3 chk("t6_rst_count", 32'(cnt[1]), 32'd0); chk("t6_rst_mis", 32'(mis[1]), 32'd0);
    chk("t6_rst_instr", 32'(iout[1]), 32'd0); chk("t6_rst_en", 32'(pc_en[1]), 32'd1);
    chk("t6_rst_valid", 32'(ivalid[1]), 32'd0);
    @(negedge clk); rst[1] = 1'b0;
    repeat (4) @(negedge clk);
    #3 chk("t6_reboot_instr", 32'(iout[1]), 32'h1234); chk("t6_reboot_valid", 32'(ivalid[1]), 32'd1);
    @(negedge clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
